cmd_pulse_executor: RTL

//  Sync/execution stage downstream of the command-memory writer. Requests the next

---
 rtl/cmd_pulse_executor.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_pulse_executor.sv
// ============================================================================
// Module : cmd_pulse_executor
// Brief  : Fetches one time-tagged command and plays its blanked pulse train.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cmd_pulse_executor #(
  parameter int unsigned LATE_MAX    = 48,
  parameter int unsigned REQ_TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        EN,
  input  logic        ABORT,
  input  logic [63:0] TIME,
  input  logic        DATA_WR,
  input  logic [47:0] FREQ,
  input  logic [47:0] FREQ_STEP,
  input  logic [31:0] FREQ_RATE,
  input  logic [63:0] TIME_START,
  input  logic [15:0] N_impulse,
  input  logic [1:0]  TYPE_impulse,
  input  logic [31:0] Interval_Ti,
  input  logic [31:0] Interval_Tp,
  input  logic [31:0] Tblank1,
  input  logic [31:0] Tblank2,
  output logic        REQ_COMM,
  output logic        BUSY,
  output logic        IMP_OUT,
  output logic        BLANK,
  output logic [47:0] FREQ_OUT,
  output logic [15:0] IMP_CNT,
  output logic        DONE,
  output logic        ERR_LATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_CHECK = 3'd2,
    S_ARMED = 3'd3,
    S_PRE   = 3'd4,
    S_PULSE = 3'd5,
    S_POST  = 3'd6,
    S_GAP   = 3'd7
  } state_t;

  localparam logic [1:0] c_TYPE_CHIRP = 2'd1;
  localparam logic [1:0] c_TYPE_STEP  = 2'd2;

  state_t      r_state;
  logic [47:0] r_freq, r_step, r_acc, r_fout;
  logic [31:0] r_rate, r_ti, r_tp, r_tb1, r_tb2;
  logic [63:0] r_ts;
  logic [15:0] r_n, r_imp_cnt;
  logic [1:0]  r_type;
  logic        r_late;
  logic [31:0] r_cnt, r_per, r_rc, r_to;
  logic        r_req, r_busy, r_imp, r_blank, r_done, r_err;

  logic [31:0] w_rate_eff;
  logic        w_time_ok, w_late_now, w_last_pulse;
  logic        w_start, w_end, w_last;

  assign w_rate_eff   = (r_rate == 32'd0) ? 32'd1 : r_rate;
  assign w_time_ok    = (TIME >= r_ts);
  // Widened by one bit so TIME_START near the top of the range cannot wrap.
  assign w_late_now   = ({1'b0, TIME} > ({1'b0, TIME_START} + 65'(LATE_MAX)));
  assign w_last_pulse = ((r_imp_cnt + 16'd1) == r_n);

  // Phase boundaries: w_end marks the last blanked clock of a pulse slot,
  // w_start requests the first clock of the next pulse.
  always_comb begin
    w_start = 1'b0;
    w_end   = 1'b0;
    w_last  = 1'b0;
    case (r_state)
      S_ARMED: w_start = w_time_ok && (r_tb1 == 32'd0);
      S_PRE:   w_start = (r_cnt == 32'd1);
      S_PULSE: if (r_cnt == 32'd1 && r_tb2 == 32'd0) begin
                 w_end  = 1'b1;
                 w_last = w_last_pulse;
               end
      S_POST:  if (r_cnt == 32'd1) begin
                 w_end  = 1'b1;
                 w_last = (r_imp_cnt == r_n);
               end
      S_GAP:   w_start = (r_per <= 32'd1);
      default: ;
    endcase
    if (w_end && !w_last && r_per <= 32'd1)
      w_start = 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_freq    <= '0;
      r_step    <= '0;
      r_acc     <= '0;
      r_fout    <= '0;
      r_rate    <= '0;
      r_ti      <= '0;
      r_tp      <= '0;
      r_tb1     <= '0;
      r_tb2     <= '0;
      r_ts      <= '0;
      r_n       <= '0;
      r_imp_cnt <= '0;
      r_type    <= '0;
      r_late    <= 1'b0;
      r_cnt     <= '0;
      r_per     <= '0;
      r_rc      <= '0;
      r_to      <= '0;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_imp     <= 1'b0;
      r_blank   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // Clocks remaining in the current pulse period; saturates at zero.
      if (r_per != 32'd0)
        r_per <= r_per - 32'd1;

      if (ABORT) begin
        r_state <= S_IDLE;
        r_req   <= 1'b0;
        r_busy  <= 1'b0;
        r_imp   <= 1'b0;
        r_blank <= 1'b0;
        r_fout  <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (EN) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_to    <= 32'(REQ_TIMEOUT);
          end
          S_REQ: begin
            if (r_req && DATA_WR) begin
              r_freq    <= FREQ;
              r_acc     <= FREQ;
              r_step    <= FREQ_STEP;
              r_rate    <= FREQ_RATE;
              r_ts      <= TIME_START;
              r_n       <= N_impulse;
              r_type    <= TYPE_impulse;
              r_ti      <= Interval_Ti;
              r_tp      <= Interval_Tp;
              r_tb1     <= Tblank1;
              r_tb2     <= Tblank2;
              r_late    <= w_late_now;
              r_imp_cnt <= '0;
              r_req     <= 1'b0;
              r_state   <= S_CHECK;
            end else if (!EN) begin
              r_req   <= 1'b0;
              r_state <= S_IDLE;
            end else if (!r_req) begin
              r_req <= 1'b1;
              r_to  <= 32'(REQ_TIMEOUT);
            end else if (r_to == 32'd1) begin
              r_req <= 1'b0;
            end else begin
              r_to <= r_to - 32'd1;
            end
          end
          S_CHECK: begin
            if (r_late || r_ti == 32'd0) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else if (r_n == 16'd0) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_ARMED;
            end
          end
          S_ARMED: if (w_time_ok && r_tb1 != 32'd0) begin
            r_state <= S_PRE;
            r_blank <= 1'b1;
            r_cnt   <= r_tb1;
          end
          S_PRE: if (r_cnt != 32'd1)
            r_cnt <= r_cnt - 32'd1;
          S_PULSE: begin
            if (r_cnt == 32'd1) begin
              r_imp_cnt <= r_imp_cnt + 16'd1;
              r_imp     <= 1'b0;
              r_fout    <= '0;
              if (r_tb2 != 32'd0) begin
                r_state <= S_POST;
                r_cnt   <= r_tb2;
              end
            end else begin
              r_cnt <= r_cnt - 32'd1;
              if (r_type == c_TYPE_CHIRP) begin
                if (r_rc == 32'd1) begin
                  r_fout <= r_fout + r_step;
                  r_rc   <= w_rate_eff;
                end else begin
                  r_rc <= r_rc - 32'd1;
                end
              end
            end
          end
          S_POST: if (r_cnt != 32'd1)
            r_cnt <= r_cnt - 32'd1;
          default: ;
        endcase

        if (w_end) begin
          r_blank <= 1'b0;
          if (w_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!w_start) begin
            r_state <= S_GAP;
          end
        end

        // Step mode advances the base at each pulse start, so back-to-back
        // pulses never read a stale accumulator.
        if (w_start) begin
          r_state <= S_PULSE;
          r_imp   <= 1'b1;
          r_blank <= 1'b1;
          r_cnt   <= r_ti;
          r_per   <= r_tp;
          r_rc    <= w_rate_eff;
          if (r_type == c_TYPE_STEP) begin
            r_fout <= r_acc;
            r_acc  <= r_acc + r_step;
          end else begin
            r_fout <= r_freq;
          end
        end
      end
    end
  end

  assign REQ_COMM = r_req;
  assign BUSY     = r_busy;
  assign IMP_OUT  = r_imp;
  assign BLANK    = r_blank;
  assign FREQ_OUT = r_fout;
  assign IMP_CNT  = r_imp_cnt;
  assign DONE     = r_done;
  assign ERR_LATE = r_err;

endmodule

`default_nettype wire
